// File: rtl/llm_int8_gather.sv
// llm_int8_gather: merges the outlier (large) and int8 (small) matmul result streams.
// Each path is buffered in its own FIFO; heads are paired in arrival order and summed
// element-wise into a single output register with optional saturation.
module llm_int8_gather #(
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned OUT_ROWS    = 20,
  parameter int unsigned OUT_COLUMNS = 1,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [OUT_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]   data_in_large,
  input  logic                                        data_in_large_valid,
  output logic                                        data_in_large_ready,
  input  logic [OUT_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]   data_in_small,
  input  logic                                        data_in_small_valid,
  output logic                                        data_in_small_ready,
  output logic [OUT_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]   data_out,
  output logic                                        data_out_valid,
  input  logic                                        data_out_ready
);

  localparam int unsigned N  = OUT_ROWS * OUT_COLUMNS;
  localparam int unsigned BW = OUT_WIDTH * N;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FullCnt = FIFO_DEPTH[PW:0];

  // Output slot states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [BW-1:0] large_mem [FIFO_DEPTH];
  logic [BW-1:0] small_mem [FIFO_DEPTH];
  logic [PW-1:0] large_wr_q, large_rd_q, small_wr_q, small_rd_q;
  logic [PW:0]   large_cnt_q, small_cnt_q;
  logic [0:0]    state_q;

  logic large_push, small_push, pop;
  logic large_full, small_full, large_nonempty, small_nonempty;
  logic [BW-1:0] head_large, head_small, sum_vec;

  assign large_full     = (large_cnt_q == FullCnt);
  assign small_full     = (small_cnt_q == FullCnt);
  assign large_nonempty = (large_cnt_q != '0);
  assign small_nonempty = (small_cnt_q != '0);

  // No push-through: ready depends only on stored occupancy, never on a same-cycle pop.
  assign data_in_large_ready = !large_full && !rst;
  assign data_in_small_ready = !small_full && !rst;

  assign large_push = data_in_large_valid && data_in_large_ready;
  assign small_push = data_in_small_valid && data_in_small_ready;

  assign data_out_valid = (state_q == ST_FULL);
  assign pop = large_nonempty && small_nonempty && (!data_out_valid || data_out_ready);

  assign head_large = large_mem[large_rd_q];
  assign head_small = small_mem[small_rd_q];

  // Large-path FIFO: storage, wrapping pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      large_wr_q  <= '0;
      large_rd_q  <= '0;
      large_cnt_q <= '0;
    end else begin
      if (large_push) begin
        large_mem[large_wr_q] <= data_in_large;
        large_wr_q            <= large_wr_q + 1'b1;
      end
      if (pop) large_rd_q <= large_rd_q + 1'b1;
      if (large_push && !pop)      large_cnt_q <= large_cnt_q + 1'b1;
      else if (!large_push && pop) large_cnt_q <= large_cnt_q - 1'b1;
    end
  end

  // Small-path FIFO: storage, wrapping pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      small_wr_q  <= '0;
      small_rd_q  <= '0;
      small_cnt_q <= '0;
    end else begin
      if (small_push) begin
        small_mem[small_wr_q] <= data_in_small;
        small_wr_q            <= small_wr_q + 1'b1;
      end
      if (pop) small_rd_q <= small_rd_q + 1'b1;
      if (small_push && !pop)      small_cnt_q <= small_cnt_q + 1'b1;
      else if (!small_push && pop) small_cnt_q <= small_cnt_q - 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_elem
    logic [OUT_WIDTH-1:0] a, b;
    logic [OUT_WIDTH:0]   sum;
    assign a = head_large[g*OUT_WIDTH +: OUT_WIDTH];
    assign b = head_small[g*OUT_WIDTH +: OUT_WIDTH];

    // Sign-extended add; top two bits differing means the result left the signed range
    always_comb begin
      sum = {a[OUT_WIDTH-1], a} + {b[OUT_WIDTH-1], b};
      sum_vec[g*OUT_WIDTH +: OUT_WIDTH] = sum[OUT_WIDTH-1:0];
      if ((SATURATE != 0) && (sum[OUT_WIDTH] != sum[OUT_WIDTH-1])) begin
        sum_vec[g*OUT_WIDTH +: OUT_WIDTH] = sum[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                          : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

  // Output slot: load on pop, drain when accepted with nothing new, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      data_out <= '0;
    end else if (pop) begin
      state_q  <= ST_FULL;
      data_out <= sum_vec;
    end else if (data_out_ready) begin
      state_q  <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_llm_int8_gather.sv
// Directed bench for llm_int8_gather: reset, latency, skew, saturation, backpressure,
// a bounded random stream and reset with blocks in flight.
module tb_llm_int8_gather;
  localparam int W  = 32;
  localparam int N  = 20;
  localparam int BW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] data_in_large, data_in_small;
  logic          data_in_large_valid, data_in_small_valid;
  logic          data_in_large_ready, data_in_small_ready;
  logic [BW-1:0] data_out;
  logic          data_out_valid, data_out_ready;
  logic [BW-1:0] wrap_out;
  logic          wrap_valid, wrap_lready, wrap_sready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [BW-1:0] lq [64];
  logic [BW-1:0] sq [64];
  int ltot, stot, nl, ns, nout;

  always #5 clk = ~clk;

  llm_int8_gather #(.OUT_WIDTH(W), .OUT_ROWS(N), .OUT_COLUMNS(1), .FIFO_DEPTH(2), .SATURATE(1))
  dut (
    .clk(clk), .rst(rst),
    .data_in_large(data_in_large), .data_in_large_valid(data_in_large_valid),
    .data_in_large_ready(data_in_large_ready),
    .data_in_small(data_in_small), .data_in_small_valid(data_in_small_valid),
    .data_in_small_ready(data_in_small_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  llm_int8_gather #(.OUT_WIDTH(W), .OUT_ROWS(N), .OUT_COLUMNS(1), .FIFO_DEPTH(2), .SATURATE(0))
  dut_wrap (
    .clk(clk), .rst(rst),
    .data_in_large(data_in_large), .data_in_large_valid(data_in_large_valid),
    .data_in_large_ready(wrap_lready),
    .data_in_small(data_in_small), .data_in_small_valid(data_in_small_valid),
    .data_in_small_ready(wrap_sready),
    .data_out(wrap_out), .data_out_valid(wrap_valid), .data_out_ready(data_out_ready)
  );

  task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element i = base + step*i
  function automatic logic [BW-1:0] ramp(input int base, input int step);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = 32'(base + step * i);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_add(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b, input bit sat);
    longint s;
    s = longint'(a) + longint'(b);
    if (sat && s > 64'sd2147483647)  s = 64'sd2147483647;
    if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
    return s[W-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_blk(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = ref_add(a[i*W +: W], b[i*W +: W], 1'b1);
    return r;
  endfunction

  task automatic reset_sb();
    nl = 0;
    ns = 0;
    nout = 0;
  endtask

  // One cycle of queue-driven traffic; any accepted output is checked against the model
  task automatic drive_cycle(input bit en_l, input bit en_s, input bit rdy);
    bit fl, fs, fo;
    if (nl < ltot) data_in_large = lq[nl];
    if (ns < stot) data_in_small = sq[ns];
    data_in_large_valid = en_l && (nl < ltot);
    data_in_small_valid = en_s && (ns < stot);
    data_out_ready = rdy;
    #1;
    fl = data_in_large_valid && data_in_large_ready;
    fs = data_in_small_valid && data_in_small_ready;
    fo = data_out_valid && rdy;
    if (fo) begin
      chk_blk("stream_data", data_out, ref_blk(lq[nout], sq[nout]));
      nout++;
    end
    tick();
    if (fl) nl++;
    if (fs) ns++;
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    data_in_large = '0;
    data_in_small = '0;
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    data_out_ready = 1'b0;
    ltot = 0;
    stot = 0;
    reset_sb();

    // Reset state
    tick();
    tick();
    chk_int("rst_lready", int'(data_in_large_ready), 0);
    chk_int("rst_sready", int'(data_in_small_ready), 0);
    chk_int("rst_valid", int'(data_out_valid), 0);
    chk_blk("rst_data", data_out, '0);
    rst = 1'b0;
    #1;
    chk_int("post_rst_lready", int'(data_in_large_ready), 1);
    chk_int("post_rst_sready", int'(data_in_small_ready), 1);

    // Single pair: 1000*i + (-3), two-cycle latency, one cycle of valid
    data_out_ready = 1'b1;
    data_in_large = ramp(0, 1000);
    data_in_small = ramp(-3, 0);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    chk_int("single_lat1_valid", int'(data_out_valid), 0);
    tick();
    chk_int("single_valid", int'(data_out_valid), 1);
    chk_blk("single_data", data_out, ramp(-3, 1000));
    tick();
    chk_int("single_drop", int'(data_out_valid), 0);

    // Skew: two large blocks fill the large FIFO before any small block arrives
    data_in_large = ramp(5, 0);
    data_in_large_valid = 1'b1;
    tick();
    data_in_large = ramp(6, 0);
    tick();
    data_in_large_valid = 1'b0;
    chk_int("skew_full_lready", int'(data_in_large_ready), 0);
    repeat (10) tick();
    chk_int("skew_wait_lready", int'(data_in_large_ready), 0);
    chk_int("skew_wait_valid", int'(data_out_valid), 0);
    data_in_small = ramp(10, 0);
    data_in_small_valid = 1'b1;
    tick();
    chk_int("skew_s1_lready", int'(data_in_large_ready), 0);
    data_in_small = ramp(20, 0);
    tick();
    data_in_small_valid = 1'b0;
    chk_int("skew_pop_lready", int'(data_in_large_ready), 1);
    chk_int("skew_out0_valid", int'(data_out_valid), 1);
    chk_blk("skew_out0", data_out, ramp(15, 0));
    tick();
    chk_int("skew_out1_valid", int'(data_out_valid), 1);
    chk_blk("skew_out1", data_out, ramp(26, 0));
    tick();
    chk_int("skew_drain", int'(data_out_valid), 0);

    // Saturation vs wrap, positive then negative overflow
    data_in_large = ramp(32'h7FFF_FFF0, 0);
    data_in_small = ramp(32'h20, 0);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    data_in_large = ramp(int'(32'h8000_0000), 0);
    data_in_small = ramp(-1, 0);
    tick();
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    chk_blk("sat_pos", data_out, ramp(32'h7FFF_FFFF, 0));
    chk_blk("wrap_pos", wrap_out, ramp(int'(32'h8000_0010), 0));
    tick();
    chk_blk("sat_neg", data_out, ramp(int'(32'h8000_0000), 0));
    chk_blk("wrap_neg", wrap_out, ramp(32'h7FFF_FFFF, 0));
    tick();
    chk_int("sat_drain", int'(data_out_valid), 0);
    chk_int("wrap_drain", int'(wrap_valid), 0);

    // Backpressure: 4 blocks per path, output stalled for 8 cycles; each sum is 100+3k
    reset_sb();
    ltot = 4;
    stot = 4;
    for (int k = 0; k < 4; k++) begin
      lq[k] = ramp(100 + k, 1);
      sq[k] = ramp(2 * k, -1);
    end
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0);
    chk_blk("bp_hold_early", data_out, ramp(100, 0));
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);
    chk_int("bp_valid", int'(data_out_valid), 1);
    chk_blk("bp_hold_late", data_out, ramp(100, 0));
    chk_int("bp_lready", int'(data_in_large_ready), 0);
    chk_int("bp_sready", int'(data_in_small_ready), 0);
    chk_int("bp_nl", nl, 3);
    chk_int("bp_ns", ns, 3);
    repeat (4) drive_cycle(1'b1, 1'b1, 1'b1);
    chk_int("bp_emitted", nout, 4);
    chk_int("bp_drain", int'(data_out_valid), 0);

    // Random valid/ready on all three channels, bounded by a cycle budget
    reset_sb();
    ltot = 48;
    stot = 48;
    for (int k = 0; k < 48; k++) begin
      for (int i = 0; i < N; i++) begin
        lq[k][i*W +: W] = $urandom();
        sq[k][i*W +: W] = $urandom();
      end
    end
    cyc = 0;
    while (nout < 48 && cyc < 3000) begin
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk_int("rand_count", nout, 48);
    chk_int("rand_drain", int'(data_out_valid), 0);

    // Reset with one block in the output register and one in each FIFO
    reset_sb();
    ltot = 2;
    stot = 2;
    lq[0] = ramp(1, 1);
    sq[0] = ramp(1, 1);
    lq[1] = ramp(50, 0);
    sq[1] = ramp(60, 0);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0);
    chk_int("mid_loaded_valid", int'(data_out_valid), 1);
    rst = 1'b1;
    tick();
    chk_int("mid_rst_valid", int'(data_out_valid), 0);
    chk_blk("mid_rst_data", data_out, '0);
    chk_int("mid_rst_lready", int'(data_in_large_ready), 0);
    rst = 1'b0;
    #1;
    chk_int("mid_post_lready", int'(data_in_large_ready), 1);
    data_in_large = ramp(7, 0);
    data_in_small = ramp(-9, 0);
    data_in_large_valid = 1'b1;
    data_in_small_valid = 1'b1;
    tick();
    data_in_large_valid = 1'b0;
    data_in_small_valid = 1'b0;
    chk_int("mid_lat1_valid", int'(data_out_valid), 0);
    tick();
    chk_int("mid_fresh_valid", int'(data_out_valid), 1);
    chk_blk("mid_fresh_data", data_out, ramp(-2, 0));
    data_out_ready = 1'b1;
    tick();
    chk_int("mid_no_leftover", int'(data_out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
